// File: rtl/ui_pkg.sv
// Shared UI definitions: device codes, input line counts and event-register bit layout.
package ui_pkg;

    typedef enum logic [1:0] {
        UI_KEY  = 2'd0,
        UI_SW   = 2'd1,
        UI_LEDR = 2'd2,
        UI_HEX  = 2'd3
    } ui_dev_e;

    localparam int unsigned UI_NKEYS       = 4;
    localparam int unsigned UI_NSW         = 10;
    localparam int unsigned UI_NLINES      = UI_NKEYS + UI_NSW;
    localparam int unsigned UI_EVT_KEY_LSB = 0;
    localparam int unsigned UI_EVT_SW_LSB  = UI_EVT_KEY_LSB + UI_NKEYS;

    // Event payload; field order matches the LSB offsets above.
    typedef struct packed {
        logic [UI_NSW-1:0]   sw;
        logic [UI_NKEYS-1:0] key;
    } ui_evt_t;

endpackage

// File: rtl/debounce_bit.sv
// One input line: two-flop synchronizer followed by a stable-for-N-cycles debouncer.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNTW            = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // Count consecutive mismatches; accept the new level on the last one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/ui_input_conditioner.sv
// Board input conditioner: debounced key/switch levels plus a sticky clear-on-read
// event register (key presses, switch toggles) and its interrupt.
module ui_input_conditioner
    import ui_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNTW            = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [UI_NKEYS-1:0] KEY_RAW,
    input  logic [UI_NSW-1:0]   SW_RAW,
    input  logic                evtRdEn,
    output logic [UI_NKEYS-1:0] KEYS,
    output logic [UI_NSW-1:0]   SWITCHES,
    output logic [DBITS-1:0]    evtOut,
    output logic                irq
);

    logic [UI_NLINES-1:0] raw_c;
    logic [UI_NLINES-1:0] stable_c;
    logic [UI_NLINES-1:0] prev_q;
    ui_evt_t              set_c;
    ui_evt_t              evt_d;
    ui_evt_t              evt_q;

    // Keys are active-low on the board; invert so every line is active-high.
    assign raw_c = {SW_RAW, ~KEY_RAW};

    for (genvar g = 0; g < UI_NLINES; g++) begin : g_line
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNTW           (CNTW)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (raw_c[g]),
            .stable_o(stable_c[g])
        );
    end

    assign KEYS     = stable_c[UI_EVT_KEY_LSB +: UI_NKEYS];
    assign SWITCHES = stable_c[UI_EVT_SW_LSB +: UI_NSW];

    // Press-only for keys, both directions for switches; a new event beats the read clear.
    always_comb begin
        set_c.key = KEYS & ~prev_q[UI_EVT_KEY_LSB +: UI_NKEYS];
        set_c.sw  = SWITCHES ^ prev_q[UI_EVT_SW_LSB +: UI_NSW];
        evt_d.key = (evtRdEn ? '0 : evt_q.key) | set_c.key;
        evt_d.sw  = (evtRdEn ? '0 : evt_q.sw) | set_c.sw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            evt_q  <= '0;
        end else begin
            prev_q <= stable_c;
            evt_q  <= evt_d;
        end
    end

    assign evtOut = DBITS'({evt_q.sw, evt_q.key});
    assign irq    = |{evt_q.sw, evt_q.key};

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Directed plus randomized checks of ui_input_conditioner against a sliding-window
// debounce model and an event-register model.
module tb_ui_input_conditioner;

    localparam int unsigned DC    = 4;
    localparam int unsigned DBITS = 32;
    localparam int unsigned NL    = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       KEY_RAW;
    logic [9:0]       SW_RAW;
    logic             evtRdEn;
    logic [3:0]       KEYS;
    logic [9:0]       SWITCHES;
    logic [DBITS-1:0] evtOut;
    logic             irq;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: raw sample history per line (index 0 = newest), accepted levels, events.
    logic          hist [NL][DC+1];
    logic [NL-1:0] m_st;
    logic [NL-1:0] m_prev;
    logic [NL-1:0] m_evt;

    always #5 clk = ~clk;

    ui_input_conditioner #(
        .DBITS          (DBITS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .KEY_RAW (KEY_RAW),
        .SW_RAW  (SW_RAW),
        .evtRdEn (evtRdEn),
        .KEYS    (KEYS),
        .SWITCHES(SWITCHES),
        .evtOut  (evtOut),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A line takes a new level once the DC synchronized samples that reached the
    // debouncer by this edge (raw delayed two edges) all disagree with its level.
    task automatic model_edge(input logic rst, input logic [NL-1:0] raw, input logic rd);
        logic [NL-1:0] nxt;
        logic [NL-1:0] set;
        if (rst) begin
            for (int l = 0; l < NL; l++)
                for (int d = 0; d <= DC; d++) hist[l][d] = 1'b0;
            m_st   = '0;
            m_prev = '0;
            m_evt  = '0;
        end else begin
            set[3:0]  = m_st[3:0] & ~m_prev[3:0];
            set[13:4] = m_st[13:4] ^ m_prev[13:4];
            m_evt     = (rd ? '0 : m_evt) | set;
            m_prev    = m_st;
            for (int l = 0; l < NL; l++) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int d = 1; d <= DC; d++)
                    if (hist[l][d] == m_st[l]) all_diff = 1'b0;
                nxt[l] = all_diff ? ~m_st[l] : m_st[l];
                for (int d = DC; d > 0; d--) hist[l][d] = hist[l][d-1];
                hist[l][0] = raw[l];
            end
            m_st = nxt;
        end
    endtask

    task automatic check_model();
        check("keys",   32'(KEYS),     32'(m_st[3:0]));
        check("sw",     32'(SWITCHES), 32'(m_st[13:4]));
        check("evtout", evtOut,        32'(m_evt));
        check("irq",    32'(irq),      32'(|m_evt));
    endtask

    task automatic step(input logic rst, input logic [3:0] k, input logic [9:0] s, input logic rd);
        reset   = rst;
        KEY_RAW = k;
        SW_RAW  = s;
        evtRdEn = rd;
        @(posedge clk);
        model_edge(rst, {s, ~k}, rd);
        #1;
        check_model();
    endtask

    initial begin
        logic [3:0] rk;
        logic [9:0] rs;
        logic       rrst;
        logic       rrd;

        // Reset held three cycles with keys released
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 10'h000, 1'b0);
        check("rst_keys", 32'(KEYS), 32'h0);
        check("rst_sw",   32'(SWITCHES), 32'h0);
        check("rst_evt",  evtOut, 32'h0);
        check("rst_irq",  32'(irq), 32'h0);
        step(1'b0, 4'hF, 10'h000, 1'b0);
        step(1'b0, 4'hF, 10'h000, 1'b0);

        // Clean press of key 0
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 4'hE, 10'h000, 1'b0);
            if (i == 5) check("press_keys5", 32'(KEYS), 32'h0);
        end
        check("press_keys6", 32'(KEYS), 32'h1);
        check("press_evt6",  evtOut, 32'h0);
        step(1'b0, 4'hE, 10'h000, 1'b0);
        check("press_evt7", evtOut, 32'h1);
        check("press_irq7", 32'(irq), 32'h1);
        for (int i = 0; i < 10; i++) step(1'b0, 4'hF, 10'h000, 1'b0);
        check("release_keys", 32'(KEYS), 32'h0);
        check("release_evt",  evtOut, 32'h1);

        // Switch 3 glitch of three cycles is ignored
        for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 10'h008, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'hF, 10'h000, 1'b0);
        check("glitch_sw",  32'(SWITCHES), 32'h0);
        check("glitch_evt", evtOut, 32'h1);

        // Bounce 1-0-1-0 (two cycles each), then steady high
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'hF, ((i / 2) % 2 == 0) ? 10'h008 : 10'h000, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 4'hF, 10'h008, 1'b0);
            if (i == 5) check("bounce_sw5", 32'(SWITCHES), 32'h0);
        end
        check("bounce_sw6", 32'(SWITCHES), 32'h008);
        step(1'b0, 4'hF, 10'h008, 1'b0);
        check("bounce_evt", evtOut, 32'h81);

        // Clear-on-read: pre-clear value visible during the strobe
        evtRdEn = 1'b1;
        #1;
        check("rd_during", evtOut, 32'h81);
        step(1'b0, 4'hF, 10'h008, 1'b1);
        check("rd_after_evt", evtOut, 32'h0);
        check("rd_after_irq", 32'(irq), 32'h0);

        // Key 2 event lands on the same edge as a read strobe
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, (i >= 3) ? 4'hB : 4'hF, 10'h009, (i == 9) ? 1'b1 : 1'b0);
            if (i == 8) begin
                check("simul_pre_evt",  evtOut, 32'h10);
                check("simul_pre_keys", 32'(KEYS), 32'h4);
            end
        end
        check("simul_post_evt", evtOut, 32'h4);
        for (int i = 0; i < 8; i++) step(1'b0, 4'hF, 10'h009, 1'b0);

        // Reset in the middle of a key 1 debounce
        for (int i = 0; i < 3; i++) step(1'b0, 4'hD, 10'h009, 1'b0);
        step(1'b1, 4'hD, 10'h009, 1'b0);
        check("midrst_keys", 32'(KEYS), 32'h0);
        check("midrst_evt",  evtOut, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 4'hD, 10'h009, 1'b0);
            if (i == 5) check("midrst_keys5", 32'(KEYS), 32'h0);
        end
        check("midrst_keys6", 32'(KEYS), 32'h2);

        // Randomized toggling, read strobes and occasional resets
        rk = 4'hD;
        rs = 10'h009;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) rk[b] = ~rk[b];
            for (int b = 0; b < 10; b++)
                if ($urandom_range(7) == 0) rs[b] = ~rs[b];
            rrst = ($urandom_range(399) == 0);
            rrd  = ($urandom_range(5) == 0);
            step(rrst, rk, rs, rrd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
